// File: rtl/bus_arbiter_ctrl.sv
// Round-robin arbiter/sequencer for four requesters sharing the 16-bit packet bus.
// Granted payloads are framed as {4'hF, payload, seq}; downstream errors park the bus in HOLD.
module bus_arbiter_ctrl #(
  parameter int BUS_SIZE     = 16,
  parameter int PAYLOAD_SIZE = 8,
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*PAYLOAD_SIZE-1:0] payload,
  input  logic                            error_in,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [BUS_SIZE-1:0]             data_out,
  output logic                            valid_out,
  output logic [1:0]                      arb_state,
  output logic [7:0]                      err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [BUS_SIZE-1:0]       data_q, data_d;
  logic                      valid_q, valid_d;
  logic [3:0]                seq_q, seq_d;
  logic [3:0]                burst_q, burst_d;
  logic [1:0]                last_q, last_d;
  logic [7:0]                err_q, err_d;

  logic [7:0]                req2_s;
  logic [3:0]                rot_s;
  logic [1:0]                off_s;
  logic [1:0]                pick_s;
  logic [PAYLOAD_SIZE-1:0]   payload_sel_s;
  logic [7:0]                err_inc_s;
  logic                      burst_last_s;

  // Rotate requests so bit 0 is the requester just after the previous owner.
  always_comb begin
    req2_s = {req, req};
    rot_s  = req2_s[({1'b0, last_q} + 3'd1) +: 4];
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    pick_s        = last_q + 2'd1 + off_s;
    payload_sel_s = payload[{last_q, 3'b000} +: PAYLOAD_SIZE];
    err_inc_s     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    burst_last_s  = (({1'b0, burst_q} + 5'd1) == 5'(MAX_BURST));
  end

  // Next-state and output computation for the arbiter FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    seq_d   = seq_q;
    burst_d = burst_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = 4'b0000;
        if (error_in) begin
          state_d = ST_HOLD;
          err_d   = err_inc_s;
        end else if (|req) begin
          state_d = ST_BUSY;
          gnt_d   = 4'b0001 << pick_s;
          last_d  = pick_s;
          burst_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (error_in) begin
          state_d = ST_HOLD;
          gnt_d   = 4'b0000;
          err_d   = err_inc_s;
        end else if (!req[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
        end else begin
          data_d  = {4'hF, payload_sel_s, seq_q};
          valid_d = 1'b1;
          seq_d   = seq_q + 4'd1;
          burst_d = burst_q + 4'd1;
          if (burst_last_s) begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_HOLD: begin
        gnt_d = 4'b0000;
        if (error_in) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
          seq_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers; last_owner resets to 3 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      seq_q   <= 4'd0;
      burst_q <= 4'd0;
      last_q  <= 2'd3;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      seq_q   <= seq_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign arb_state = state_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Directed self-checking bench for bus_arbiter_ctrl (default MAX_BURST = 4).
module tb_bus_arbiter_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] payload;
  logic        error_in;
  logic [3:0]  gnt;
  logic [15:0] data_out;
  logic        valid_out;
  logic [1:0]  arb_state;
  logic [7:0]  err_count;

  int checks = 0;
  int passes = 0;
  logic [3:0] seq_e;

  bus_arbiter_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .payload(payload), .error_in(error_in),
    .gnt(gnt), .data_out(data_out), .valid_out(valid_out),
    .arb_state(arb_state), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 4'b0000; payload = 32'h0; error_in = 1'b0;
    step; step;
    checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", gnt); else passes++;
    checks++; if (data_out !== 16'h0000) $display("FAIL reset_data got %h exp 0000", data_out); else passes++;
    checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_out); else passes++;
    checks++; if (arb_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", arb_state); else passes++;
    checks++; if (err_count !== 8'd0) $display("FAIL reset_err got %0d exp 0", err_count); else passes++;
    reset = 1'b0;
    seq_e = 4'd0;
  endtask

  task automatic test_burst;
    logic [15:0] exp_w;
    req = 4'b0001; payload = 32'h000000A5;
    step;
    checks++; if ({arb_state, gnt, valid_out} !== {2'd1, 4'b0001, 1'b0})
      $display("FAIL burst_grant got st=%0d gnt=%b v=%b exp st=1 gnt=0001 v=0", arb_state, gnt, valid_out); else passes++;
    for (int i = 0; i < 4; i++) begin
      step;
      exp_w = {4'hF, 8'hA5, seq_e};
      checks++; if ({valid_out, data_out} !== {1'b1, exp_w})
        $display("FAIL burst_word%0d got v=%b d=%h exp v=1 d=%h", i, valid_out, data_out, exp_w); else passes++;
      seq_e = seq_e + 4'd1;
    end
    checks++; if ({arb_state, gnt} !== {2'd0, 4'b0000})
      $display("FAIL burst_release got st=%0d gnt=%b exp st=0 gnt=0000", arb_state, gnt); else passes++;
    step;
    checks++; if ({valid_out, gnt} !== {1'b0, 4'b0001})
      $display("FAIL burst_regrant got v=%b gnt=%b exp v=0 gnt=0001", valid_out, gnt); else passes++;
    req = 4'b0000;
    step;
    checks++; if ({valid_out, gnt, arb_state} !== {1'b0, 4'b0000, 2'd0})
      $display("FAIL burst_drop got v=%b gnt=%b st=%0d exp v=0 gnt=0000 st=0", valid_out, gnt, arb_state); else passes++;
  endtask

  // Four requesters, each burst of 4 words; seq crosses 15 -> 0 in the middle.
  task automatic test_round_robin;
    logic [1:0]  owner;
    logic [7:0]  pl;
    logic [15:0] exp_w;
    req = 4'b1111; payload = 32'h44332211;
    for (int g = 0; g < 4; g++) begin
      owner = 2'(g + 1);
      pl    = 8'(({30'd0, owner} + 32'd1) * 32'd17);
      step;
      checks++; if (gnt !== (4'b0001 << owner))
        $display("FAIL rr_grant%0d got %b exp %b", g, gnt, 4'b0001 << owner); else passes++;
      for (int w = 0; w < 4; w++) begin
        step;
        exp_w = {4'hF, pl, seq_e};
        checks++; if ({valid_out, data_out} !== {1'b1, exp_w})
          $display("FAIL rr_word%0d_%0d got v=%b d=%h exp v=1 d=%h", g, w, valid_out, data_out, exp_w); else passes++;
        seq_e = seq_e + 4'd1;
      end
      checks++; if ({arb_state, gnt} !== {2'd0, 4'b0000})
        $display("FAIL rr_release%0d got st=%0d gnt=%b exp st=0 gnt=0000", g, arb_state, gnt); else passes++;
    end
    req = 4'b0000;
    step;
    checks++; if ({arb_state, gnt, valid_out} !== {2'd0, 4'b0000, 1'b0})
      $display("FAIL rr_idle got st=%0d gnt=%b v=%b exp st=0 gnt=0000 v=0", arb_state, gnt, valid_out); else passes++;
  endtask

  task automatic test_error;
    req = 4'b0001;
    step;
    checks++; if (gnt !== 4'b0001) $display("FAIL err_grant got %b exp 0001", gnt); else passes++;
    step; step;
    checks++; if (data_out !== {4'hF, 8'h11, 4'd5}) $display("FAIL err_preword got %h exp %h", data_out, {4'hF, 8'h11, 4'd5}); else passes++;
    error_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step;
      checks++; if ({arb_state, gnt, valid_out, err_count} !== {2'd2, 4'b0000, 1'b0, 8'd1})
        $display("FAIL err_hold%0d got st=%0d gnt=%b v=%b ec=%0d exp st=2 gnt=0000 v=0 ec=1",
                 c, arb_state, gnt, valid_out, err_count); else passes++;
    end
    error_in = 1'b0;
    step;
    checks++; if ({arb_state, gnt} !== {2'd0, 4'b0000})
      $display("FAIL err_exit got st=%0d gnt=%b exp st=0 gnt=0000", arb_state, gnt); else passes++;
    step;
    checks++; if (gnt !== 4'b0001) $display("FAIL err_regrant got %b exp 0001", gnt); else passes++;
    step;
    checks++; if ({valid_out, data_out} !== {1'b1, 4'hF, 8'h11, 4'd0})
      $display("FAIL err_seq_resync got v=%b d=%h exp v=1 d=f110", valid_out, data_out); else passes++;
    req = 4'b0000;
    step;
    checks++; if ({valid_out, err_count} !== {1'b0, 8'd1})
      $display("FAIL err_after got v=%b ec=%0d exp v=0 ec=1", valid_out, err_count); else passes++;
    seq_e = 4'd1;
  endtask

  task automatic test_drop;
    req = 4'b0110;
    step;
    checks++; if (gnt !== 4'b0010) $display("FAIL drop_grant got %b exp 0010", gnt); else passes++;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++; if ({valid_out, data_out} !== {1'b1, 4'hF, 8'h22, seq_e})
        $display("FAIL drop_word%0d got v=%b d=%h exp v=1 d=%h", i, valid_out, data_out, {4'hF, 8'h22, seq_e}); else passes++;
      seq_e = seq_e + 4'd1;
    end
    req = 4'b0100;
    step;
    checks++; if ({gnt, valid_out, arb_state} !== {4'b0000, 1'b0, 2'd0})
      $display("FAIL drop_release got gnt=%b v=%b st=%0d exp gnt=0000 v=0 st=0", gnt, valid_out, arb_state); else passes++;
    step;
    checks++; if (gnt !== 4'b0100) $display("FAIL drop_next_grant got %b exp 0100", gnt); else passes++;
    step;
    checks++; if ({valid_out, data_out} !== {1'b1, 4'hF, 8'h33, seq_e})
      $display("FAIL drop_next_word got v=%b d=%h exp v=1 d=%h", valid_out, data_out, {4'hF, 8'h33, seq_e}); else passes++;
  endtask

  task automatic test_reset_busy;
    reset = 1'b1; req = 4'b0101;
    step;
    checks++; if ({arb_state, gnt, valid_out, data_out, err_count} !== {2'd0, 4'b0000, 1'b0, 16'h0000, 8'd0})
      $display("FAIL rstbusy_vals got st=%0d gnt=%b v=%b d=%h ec=%0d exp all zero",
               arb_state, gnt, valid_out, data_out, err_count); else passes++;
    reset = 1'b0;
    step;
    checks++; if (gnt !== 4'b0001) $display("FAIL rstbusy_first_grant got %b exp 0001", gnt); else passes++;
    step;
    checks++; if ({valid_out, data_out} !== {1'b1, 16'hF110})
      $display("FAIL rstbusy_word got v=%b d=%h exp v=1 d=f110", valid_out, data_out); else passes++;
    req = 4'b0000;
  endtask

  initial begin
    test_reset;
    test_burst;
    test_round_robin;
    test_error;
    test_drop;
    test_reset_busy;
    step;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_ctrl.md
Name: bus_arbiter_ctrl

Overview:
Round-robin arbiter and sequencer that shares the 16-bit packet bus among four requesters. It drives the bus_control/state_machine datapath. Each granted 8-bit payload is framed into a 16-bit word {4'hF, payload, seq[3:0]}. An error from the downstream state_machine halts all traffic and resynchronises the sequence number.

Parameters:
BUS_SIZE, 16, width of framed output word
PAYLOAD_SIZE, 8, per-requester payload width
NUM_REQ, 4, number of requesters (fixed at 4 for this revision)
MAX_BURST, 4, max words transferred per grant before forced release (1..15)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  4  request per requester; held high while the requester has data
payload  input  32  payload[8i+7:8i] belongs to requester i; must be valid while gnt[i]&&req[i]
error_in  input  1  error flag from downstream state_machine
gnt  output  4  registered one-hot grant; all-zero when no owner
data_out  output  16  registered framed word {4'hF, payload_sel, seq}
valid_out  output  1  registered; data_out carries a new word this cycle
arb_state  output  2  current state: 0 IDLE, 1 BUSY, 2 HOLD
err_count  output  8  number of HOLD entries, saturates at 255

Behaviour:
- Reset (sync, high) takes priority over everything. Values: state IDLE, gnt 0, data_out 0, valid_out 0, seq 0, burst_cnt 0, last_owner 3 (so requester 0 has first priority), err_count 0.
- Transfer condition: state BUSY && gnt[i] && req[i] && !error_in.
  - On the next edge: data_out <= {4'hF, payload[8i+7:8i], seq}, valid_out <= 1, seq <= seq+1 (wraps 15 -> 0), burst_cnt increments.
  - Latency: payload sampled in cycle N appears on data_out in cycle N+1.
- valid_out is 0 in every cycle that does not follow a transfer. data_out holds its last value when valid_out is 0.
- IDLE:
  - If error_in is high, go to HOLD.
  - Otherwise, if any req bit is high, grant the first requesting index after last_owner in cyclic order. Set gnt to that one-hot value, last_owner to that index, burst_cnt to 0, state to BUSY.
  - Otherwise stay in IDLE.
  - The grant takes effect the next cycle, so there is no transfer in the arbitration cycle.
- BUSY:
  - If error_in is high, go to HOLD; gnt <= 0, no transfer.
  - Else if req[owner] is low, go to IDLE; gnt <= 0, no transfer.
  - Else, transfer. If burst_cnt+1 == MAX_BURST, go to IDLE with gnt <= 0 (forced release); otherwise stay in BUSY.
- Every release passes through IDLE, giving exactly one bubble cycle before the next grant.
- HOLD:
  - gnt 0 and valid_out 0 throughout.
  - err_count increments once per entry into HOLD, not once per cycle, and saturates at 255.
  - Stay in HOLD while error_in is high.
  - When error_in is low, go to IDLE and set seq <= 0. last_owner is preserved, so fairness continues.
- Requests arriving while another requester is in BUSY are not lost; they are considered at the next IDLE.
- req bits of non-granted requesters never affect the current burst.
- gnt is always one-hot or zero; two gnt bits high at once is a bug.

Test Plan:
- Reset then req=4'b0001, payload[7:0]=8'hA5 held for 5 cycles:
  - gnt=0001 one cycle after req.
  - Words 16'hFA50, FA51, FA52, FA53 on consecutive cycles.
  - Forced release after 4 words, one IDLE bubble, then a regrant.
- req=4'b1111 held, payloads 11/22/33/44, MAX_BURST=1: grant order 0,1,2,3,0. data_out sequence FA11-style framing: F110, F221, F332, F443, F114 with a bubble between each.
- Sequence wrap: transfer 17 words. seq goes 0..15, then 0, 1; bit pattern low nibble 4'hF followed by 4'h0.
- error_in pulsed for 3 cycles mid-burst after seq reached 5:
  - gnt=0 and valid_out=0 the next cycle; arb_state=2 for 3 cycles; err_count=1.
  - After release, the first new word has seq=0.
- Requester drops req mid-burst after 2 words: gnt=0 next cycle, no extra valid_out, and the next pending requester in round-robin order is granted one cycle later.
- reset asserted during BUSY with valid_out=1: on the next edge all outputs are at reset values, and the first grant after reset goes to requester 0 even if requester 2 also requests.
